// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic multiplier array and its feeder.
package systolic_pkg;
  localparam int DEF_SIZE      = 3;
  localparam int DEF_IN_WIDTH  = 8;
  localparam int DEF_OUT_WIDTH = 2*DEF_IN_WIDTH + $clog2(DEF_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } feeder_state_t;

  typedef logic [0:DEF_SIZE-1][DEF_IN_WIDTH-1:0] lane_vec_t;
endpackage

// File: rtl/systolic_skew_sel.sv
// Diagonal-window lane selector: lane k carries m[k][t-k] (or m[t-k][k] when transposed).
module systolic_skew_sel #(
  parameter int SIZE     = 3,
  parameter int IN_WIDTH = 8,
  parameter int TW       = $clog2(2*SIZE)
) (
  input  logic [0:SIZE-1][0:SIZE-1][IN_WIDTH-1:0] mat,
  input  logic [TW-1:0]                           t,
  input  logic                                    transpose,
  output logic [0:SIZE-1][IN_WIDTH-1:0]           lanes
);
  // Equality scan keeps every matrix index constant; lanes outside the window stay zero.
  always_comb begin
    lanes = '0;
    for (int k = 0; k < SIZE; k++)
      for (int d = 0; d < SIZE; d++)
        if (int'(t) == k + d)
          lanes[k] = transpose ? mat[d][k] : mat[k][d];
  end
endmodule

// File: rtl/systolic_feeder.sv
// Accepts an A/B matrix pair, streams skewed beats into the systolic array and sequences its strobes.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int SIZE     = DEF_SIZE,
  parameter int IN_WIDTH = DEF_IN_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [0:SIZE-1][0:SIZE-1][IN_WIDTH-1:0] a_mat,
  input  logic [0:SIZE-1][0:SIZE-1][IN_WIDTH-1:0] b_mat,
  output logic [0:SIZE-1][IN_WIDTH-1:0]           a_in,
  output logic [0:SIZE-1][IN_WIDTH-1:0]           b_in,
  output logic                                    array_clr,
  output logic                                    load_en,
  output logic                                    mult_en,
  output logic                                    acc_en,
  output logic                                    done,
  output logic                                    busy
);
  localparam int TW = $clog2(2*SIZE);
  localparam logic [TW-1:0] T_FEED_LAST  = TW'(2*SIZE-2);
  localparam logic [TW-1:0] T_DRAIN_LAST = TW'((SIZE > 1) ? SIZE-2 : 0);

  feeder_state_t state, state_nx;
  logic [TW-1:0] t, t_nx;
  logic [0:SIZE-1][0:SIZE-1][IN_WIDTH-1:0] a_q, b_q;
  logic [0:SIZE-1][IN_WIDTH-1:0] a_sel, b_sel;
  logic accept;

  assign accept = in_valid && in_ready;

  always_comb begin
    state_nx = state;
    t_nx     = t;
    case (state)
      ST_IDLE: if (accept) begin
        state_nx = ST_CLR;
        t_nx     = '0;
      end
      ST_CLR: state_nx = ST_FEED;
      ST_FEED: if (t == T_FEED_LAST) begin
        t_nx     = '0;
        state_nx = (SIZE == 1) ? ST_DONE : ST_DRAIN;
      end else begin
        t_nx = t + 1'b1;
      end
      ST_DRAIN: if (t == T_DRAIN_LAST) begin
        t_nx     = '0;
        state_nx = ST_DONE;
      end else begin
        t_nx = t + 1'b1;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Selectors look at the upcoming beat so the lanes can be registered alongside the state.
  systolic_skew_sel #(.SIZE(SIZE), .IN_WIDTH(IN_WIDTH), .TW(TW)) u_sel_a (
    .mat(a_q), .t(t_nx), .transpose(1'b0), .lanes(a_sel)
  );
  systolic_skew_sel #(.SIZE(SIZE), .IN_WIDTH(IN_WIDTH), .TW(TW)) u_sel_b (
    .mat(b_q), .t(t_nx), .transpose(1'b1), .lanes(b_sel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      t         <= '0;
      a_q       <= '0;
      b_q       <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      array_clr <= 1'b0;
      load_en   <= 1'b0;
      mult_en   <= 1'b0;
      acc_en    <= 1'b0;
      a_in      <= '0;
      b_in      <= '0;
    end else begin
      state <= state_nx;
      t     <= t_nx;
      if (accept) begin
        a_q <= a_mat;
        b_q <= b_mat;
      end
      in_ready  <= (state_nx == ST_IDLE);
      busy      <= (state_nx != ST_IDLE);
      done      <= (state_nx == ST_DONE);
      array_clr <= (state_nx == ST_CLR);
      load_en   <= (state_nx == ST_FEED) || (state_nx == ST_DRAIN);
      mult_en   <= (state_nx == ST_FEED) || (state_nx == ST_DRAIN);
      acc_en    <= (state_nx == ST_FEED) || (state_nx == ST_DRAIN);
      a_in      <= (state_nx == ST_FEED) ? a_sel : '0;
      b_in      <= (state_nx == ST_FEED) ? b_sel : '0;
    end
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed + randomized bench for systolic_feeder with a cycle-offset reference model and array product check.
module tb_systolic_feeder;
  import systolic_pkg::*;
  localparam int S     = 3;
  localparam int W     = 8;
  localparam int NBEAT = 3*S-2;
  typedef logic [0:S-1][0:S-1][W-1:0] mat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  mat_t a_mat = '0;
  mat_t b_mat = '0;
  logic in_ready, array_clr, load_en, mult_en, acc_en, done, busy;
  lane_vec_t a_in, b_in;

  int errors = 0;
  int checks = 0;
  int ah [0:NBEAT-1][0:S-1];
  int bh [0:NBEAT-1][0:S-1];

  always #5 clk = ~clk;

  systolic_feeder #(.SIZE(S), .IN_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a_mat(a_mat), .b_mat(b_mat), .a_in(a_in), .b_in(b_in),
    .array_clr(array_clr), .load_en(load_en), .mult_en(mult_en), .acc_en(acc_en),
    .done(done), .busy(busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ctrl_now();
    return {in_ready, busy, done, array_clr, load_en, mult_en, acc_en};
  endfunction

  // Expected control word by cycle offset c after the acceptance edge.
  function automatic logic [6:0] exp_ctrl(input int c);
    if (c == 1)            return 7'b0101000;
    else if (c <= 3*S-1)   return 7'b0100111;
    else if (c == 3*S)     return 7'b0110000;
    else                   return 7'b1000000;
  endfunction

  // Row lane i at beat t is A[i][t-i]; column lane j is B[t-j][j]; zero outside.
  function automatic lane_vec_t exp_lane(input mat_t m, input int t, input bit tr);
    lane_vec_t v = '0;
    for (int k = 0; k < S; k++) begin
      int d = t - k;
      if (d >= 0 && d < S) v[k] = tr ? m[d][k] : m[k][d];
    end
    return v;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        m[i][j] = 8'($urandom_range(0, 255));
    return m;
  endfunction

  function automatic mat_t mk_mat(input int v [0:S-1][0:S-1]);
    mat_t m;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++)
        m[i][j] = 8'(v[i][j]);
    return m;
  endfunction

  function automatic lane_vec_t mk_lane(input int v [0:S-1]);
    lane_vec_t l;
    for (int k = 0; k < S; k++) l[k] = 8'(v[k]);
    return l;
  endfunction

  int lit_a [0:2*S-2][0:S-1] = '{'{1,0,0}, '{2,4,0}, '{3,5,7}, '{0,6,8}, '{0,0,9}};
  int lit_b [0:2*S-2][0:S-1] = '{'{1,0,0}, '{4,2,0}, '{7,5,3}, '{0,8,6}, '{0,0,9}};
  int lit_c [0:S-1][0:S-1]   = '{'{30,36,42}, '{66,81,96}, '{102,126,150}};

  task automatic run_job(input string name, input mat_t A, input mat_t B,
                         input bit bp, input mat_t A2, input mat_t B2, input bit lit);
    int n = 0;
    a_mat = A; b_mat = B; in_valid = 1'b1;
    while (!in_ready && n < 40) begin step; n++; end
    chk({name, "/accept_wait"}, 64'(in_ready), 64'(1));
    step;
    if (bp) begin
      a_mat = A2; b_mat = B2;
    end else begin
      in_valid = 1'b0; a_mat = rand_mat(); b_mat = rand_mat();
    end
    for (int c = 1; c <= 3*S+1; c++) begin
      lane_vec_t ea, eb;
      if (c > 1) step;
      ea = (c >= 2 && c <= 2*S) ? exp_lane(A, c-2, 1'b0) : '0;
      eb = (c >= 2 && c <= 2*S) ? exp_lane(B, c-2, 1'b1) : '0;
      chk($sformatf("%s/c%0d/ctrl", name, c), 64'(ctrl_now()), 64'(exp_ctrl(c)));
      chk($sformatf("%s/c%0d/a_in", name, c), 64'(a_in), 64'(ea));
      chk($sformatf("%s/c%0d/b_in", name, c), 64'(b_in), 64'(eb));
      if (lit && c >= 2 && c <= 2*S) begin
        chk($sformatf("%s/c%0d/a_lit", name, c), 64'(a_in), 64'(mk_lane(lit_a[c-2])));
        chk($sformatf("%s/c%0d/b_lit", name, c), 64'(b_in), 64'(mk_lane(lit_b[c-2])));
      end
      if (c >= 2 && c <= 3*S-1)
        for (int k = 0; k < S; k++) begin
          ah[c-2][k] = int'(a_in[k]);
          bh[c-2][k] = int'(b_in[k]);
        end
    end
    // PE[i][j] sees row lane i delayed j beats and column lane j delayed i beats.
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        int acc = 0;
        int ref_v = 0;
        for (int tau = 0; tau < NBEAT; tau++)
          if (tau - j >= 0 && tau - i >= 0)
            acc += ah[tau-j][i] * bh[tau-i][j];
        for (int k = 0; k < S; k++) ref_v += int'(A[i][k]) * int'(B[k][j]);
        chk($sformatf("%s/out%0d%0d", name, i, j), 64'(acc), 64'(ref_v));
        if (lit) chk($sformatf("%s/out_lit%0d%0d", name, i, j), 64'(acc), 64'(lit_c[i][j]));
      end
  endtask

  initial begin
    int seq [0:S-1][0:S-1] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}};
    int rev [0:S-1][0:S-1] = '{'{9,8,7}, '{6,5,4}, '{3,2,1}};
    int idm [0:S-1][0:S-1] = '{'{1,0,0}, '{0,1,0}, '{0,0,1}};
    mat_t ra, rb, r2a, r2b, ones;
    bit saw_done = 1'b0;

    step; step;
    chk("reset/ctrl", 64'(ctrl_now()), 64'(7'b1000000));
    chk("reset/a_in", 64'(a_in), 64'(0));
    chk("reset/b_in", 64'(b_in), 64'(0));
    reset = 1'b0;

    run_job("seq", mk_mat(seq), mk_mat(seq), 1'b0, '0, '0, 1'b1);

    // Reset pulsed while FEED beat t=2 is on the lanes.
    ra = rand_mat();
    a_mat = ra; b_mat = rand_mat(); in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    step; step; step;
    chk("midrst/t2_lane", 64'(a_in), 64'(exp_lane(ra, 2, 1'b0)));
    reset = 1'b1;
    step;
    chk("midrst/ctrl", 64'(ctrl_now()), 64'(7'b1000000));
    chk("midrst/a_in", 64'(a_in), 64'(0));
    chk("midrst/b_in", 64'(b_in), 64'(0));
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step;
      if (done) saw_done = 1'b1;
    end
    chk("midrst/no_done", 64'(saw_done), 64'(0));
    run_job("after_rst", rand_mat(), rand_mat(), 1'b0, '0, '0, 1'b0);

    ra = rand_mat(); rb = rand_mat(); r2a = rand_mat(); r2b = rand_mat();
    run_job("bp1", ra, rb, 1'b1, r2a, r2b, 1'b0);
    run_job("bp2", r2a, r2b, 1'b0, '0, '0, 1'b0);

    run_job("ident", mk_mat(idm), mk_mat(rev), 1'b0, '0, '0, 1'b0);

    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) ones[i][j] = 8'hFF;
    run_job("allff", ones, ones, 1'b0, '0, '0, 1'b0);

    for (int r = 0; r < 3; r++)
      run_job($sformatf("rand%0d", r), rand_mat(), rand_mat(), 1'b0, '0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
